// File: rtl/branch_resolve_queue_pkg.sv
// Shared types and constants for the branch resolve queue.
//   BRQ_INDEX   : PHT index width carried by each queue entry
//   BRQ_DEPTH   : default number of in-flight branch entries
//   brq_entry_t : one tracked branch {valid, resolved, idx, pred, taken}
package rv32i_types;

  localparam int BRQ_INDEX = 10;
  localparam int BRQ_DEPTH = 8;

  typedef struct packed {
    logic                 valid;
    logic                 resolved;
    logic [BRQ_INDEX-1:0] idx;
    logic                 pred;
    logic                 taken;
  } brq_entry_t;

endpackage

// File: rtl/branch_resolve_queue_sat_counter32.sv
// 32-bit saturating event counter.
//   clk   : clock
//   rst   : asynchronous reset, active-low
//   inc   : count one event this cycle
//   count : current value, sticks at 32'hFFFF_FFFF
module sat_counter32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order tracker for PHT-predicted conditional branches.
// Fetch enqueues predicted branches, execute resolves them out of order by
// slot tag, and the head retires in program order, driving the PHT update
// port. A retiring mispredict flushes every younger entry.
//
// Optional build macro BRQ_STATS_EN adds stat_retired / stat_mispred
// saturating counters.
//
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   enq_valid/idx/pred: predicted branch from fetch
//   enq_ready         : enqueue accepted this cycle
//   enq_slot          : slot tag given to the enqueue (tail pointer)
//   res_valid/slot/taken : resolution from execute
//   pht_write/pht_writeidx/pht_taken : registered PHT update
//   mispredict        : registered one-cycle pulse on a mispredicted retire
//   empty             : no entries in flight
//   stat_retired/stat_mispred : (BRQ_STATS_EN only) event counters
module branch_resolve_queue
  import rv32i_types::*;
#(
  parameter int INDEX  = BRQ_INDEX,
  parameter int DEPTH  = BRQ_DEPTH,
  parameter int SLOT_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enq_valid,
  input  logic [INDEX-1:0]  enq_idx,
  input  logic              enq_pred,
  output logic              enq_ready,
  output logic [SLOT_W-1:0] enq_slot,
  input  logic              res_valid,
  input  logic [SLOT_W-1:0] res_slot,
  input  logic              res_taken,
  output logic              pht_write,
  output logic [INDEX-1:0]  pht_writeidx,
  output logic              pht_taken,
  output logic              mispredict,
  output logic              empty
`ifdef BRQ_STATS_EN
  ,
  output logic [31:0]       stat_retired,
  output logic [31:0]       stat_mispred
`endif
);

  localparam logic [SLOT_W:0] FULL_CNT = (SLOT_W+1)'(DEPTH);

  brq_entry_t        q [DEPTH];
  logic [SLOT_W-1:0] head;
  logic [SLOT_W-1:0] tail;
  logic [SLOT_W:0]   count;

  brq_entry_t head_e;
  logic       retire;
  logic       retire_mis;
  logic       enq_fire;
  logic       res_fire;

  // Retire is decided purely from registered entry state, so a resolve to
  // the head in the same cycle only makes it eligible on the next cycle.
  assign head_e     = q[head];
  assign retire     = head_e.valid & head_e.resolved;
  assign retire_mis = retire & (head_e.pred != head_e.taken);

  assign enq_ready  = (count != FULL_CNT) & ~retire_mis;
  assign enq_fire   = enq_valid & enq_ready;
  // Resolves landing during a flush are dropped along with their entries.
  assign res_fire   = res_valid & q[res_slot].valid & ~q[res_slot].resolved & ~retire_mis;

  assign enq_slot   = tail;
  assign empty      = (count == '0);

  // Entry storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else if (retire_mis) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      // A resolved head never takes a resolve, and the tail only meets the
      // head when the queue is full (enqueue blocked) or empty (no retire).
      if (retire) q[head] <= '0;
      if (res_fire) begin
        q[res_slot].resolved <= 1'b1;
        q[res_slot].taken    <= res_taken;
      end
      if (enq_fire) begin
        q[tail] <= '{valid: 1'b1, resolved: 1'b0, idx: enq_idx,
                     pred: enq_pred, taken: 1'b0};
      end
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (retire_mis) begin
      head  <= head + SLOT_W'(1);
      tail  <= head + SLOT_W'(1);
      count <= '0;
    end else begin
      head  <= head + SLOT_W'(retire);
      tail  <= tail + SLOT_W'(enq_fire);
      count <= count + (SLOT_W+1)'(enq_fire) - (SLOT_W+1)'(retire);
    end
  end

  // Registered PHT update port; index/direction hold between updates
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pht_write    <= 1'b0;
      pht_writeidx <= '0;
      pht_taken    <= 1'b0;
      mispredict   <= 1'b0;
    end else begin
      pht_write  <= retire;
      mispredict <= retire_mis;
      if (retire) begin
        pht_writeidx <= head_e.idx;
        pht_taken    <= head_e.taken;
      end
    end
  end

`ifdef BRQ_STATS_EN
  sat_counter32 u_stat_retired (
    .clk   (clk),
    .rst   (rst),
    .inc   (retire),
    .count (stat_retired)
  );

  sat_counter32 u_stat_mispred (
    .clk   (clk),
    .rst   (rst),
    .inc   (retire_mis),
    .count (stat_mispred)
  );
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue with a scoreboard of expected PHT
// updates, consumed by a monitor whenever pht_write is seen.
module tb_branch_resolve_queue;

  logic       clk;
  logic       rst;
  logic       enq_valid;
  logic [9:0] enq_idx;
  logic       enq_pred;
  logic       enq_ready;
  logic [2:0] enq_slot;
  logic       res_valid;
  logic [2:0] res_slot;
  logic       res_taken;
  logic       pht_write;
  logic [9:0] pht_writeidx;
  logic       pht_taken;
  logic       mispredict;
  logic       empty;
`ifdef BRQ_STATS_EN
  logic [31:0] stat_retired;
  logic [31:0] stat_mispred;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [9:0] idx;
    logic       taken;
    logic       mis;
  } exp_t;
  exp_t exp_q[$];

  branch_resolve_queue dut (
    .clk          (clk),
    .rst          (rst),
    .enq_valid    (enq_valid),
    .enq_idx      (enq_idx),
    .enq_pred     (enq_pred),
    .enq_ready    (enq_ready),
    .enq_slot     (enq_slot),
    .res_valid    (res_valid),
    .res_slot     (res_slot),
    .res_taken    (res_taken),
    .pht_write    (pht_write),
    .pht_writeidx (pht_writeidx),
    .pht_taken    (pht_taken),
    .mispredict   (mispredict),
    .empty        (empty)
`ifdef BRQ_STATS_EN
    ,
    .stat_retired (stat_retired),
    .stat_mispred (stat_mispred)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Monitor samples 1 time unit after each edge; the stimulus side works
  // 2 units after the edge so the two never race.
  always @(posedge clk) begin
    #1;
    if (rst === 1'b1) begin
      if (pht_write === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pht_write", 32'(pht_write), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pht_writeidx", 32'(pht_writeidx), 32'(e.idx));
          chk("pht_taken",    32'(pht_taken),    32'(e.taken));
          chk("mispredict",   32'(mispredict),   32'(e.mis));
        end
      end else begin
        chk("mispredict_without_write", 32'(mispredict), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input logic [9:0] idx, input logic taken, input logic mis);
    exp_t e;
    e.idx = idx; e.taken = taken; e.mis = mis;
    exp_q.push_back(e);
  endtask

  task automatic enq(input logic [9:0] idx, input logic pred, input logic [2:0] exp_slot);
    enq_valid = 1'b1; enq_idx = idx; enq_pred = pred;
    chk("enq_ready", 32'(enq_ready), 32'd1);
    chk("enq_slot",  32'(enq_slot),  32'(exp_slot));
    tick();
    enq_valid = 1'b0;
  endtask

  task automatic res(input logic [2:0] slot, input logic taken);
    res_valid = 1'b1; res_slot = slot; res_taken = taken;
    tick();
    res_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [2:0] s;
    logic       tk;
    rst = 1'b0; enq_valid = 1'b0; enq_idx = '0; enq_pred = 1'b0;
    res_valid = 1'b0; res_slot = '0; res_taken = 1'b0;
    tick();
    // Reset state
    chk("rst_pht_write",    32'(pht_write),    32'd0);
    chk("rst_mispredict",   32'(mispredict),   32'd0);
    chk("rst_pht_writeidx", 32'(pht_writeidx), 32'd0);
    chk("rst_pht_taken",    32'(pht_taken),    32'd0);
    chk("rst_empty",        32'(empty),        32'd1);
    chk("rst_enq_slot",     32'(enq_slot),     32'd0);
    rst = 1'b1;
    tick();

    // Single branch, correct prediction
    enq(10'h005, 1'b1, 3'd0);
    chk("one_not_empty", 32'(empty), 32'd0);
    push_exp(10'h005, 1'b1, 1'b0);
    res(3'd0, 1'b1);
    chk("one_no_early_write", 32'(exp_q.size()), 32'd1);
    tick();
    chk("one_written", 32'(exp_q.size()), 32'd0);
    chk("one_empty",   32'(empty),        32'd1);
    tick();

    // Out-of-order resolution retires in order
    do_reset();
    enq(10'h010, 1'b0, 3'd0);
    enq(10'h011, 1'b1, 3'd1);
    enq(10'h012, 1'b0, 3'd2);
    res(3'd2, 1'b0);
    res(3'd1, 1'b1);
    tick();
    push_exp(10'h010, 1'b0, 1'b0);
    push_exp(10'h011, 1'b1, 1'b0);
    push_exp(10'h012, 1'b0, 1'b0);
    res(3'd0, 1'b0);
    tick();
    chk("ooo_left_after_1", 32'(exp_q.size()), 32'd2);
    tick();
    chk("ooo_left_after_2", 32'(exp_q.size()), 32'd1);
    tick();
    chk("ooo_left_after_3", 32'(exp_q.size()), 32'd0);
    chk("ooo_empty", 32'(empty), 32'd1);

    // Mispredict flush
    do_reset();
    for (int i = 0; i < 4; i++) enq(10'h020 + 10'(i), 1'b1, 3'(i));
    push_exp(10'h020, 1'b0, 1'b1);
    res(3'd0, 1'b0);
    chk("mis_enq_blocked", 32'(enq_ready), 32'd0);
    res_valid = 1'b1; res_slot = 3'd2; res_taken = 1'b1;
    enq_valid = 1'b1; enq_idx = 10'h099; enq_pred = 1'b1;
    tick();
    res_valid = 1'b0; enq_valid = 1'b0;
    chk("mis_written",  32'(exp_q.size()), 32'd0);
    chk("mis_empty",    32'(empty),        32'd1);
    chk("mis_next_slot", 32'(enq_slot),    32'd1);
    res(3'd2, 1'b1);
    tick();
    tick();
    chk("mis_still_empty", 32'(empty), 32'd1);
    enq(10'h030, 1'b0, 3'd1);
    push_exp(10'h030, 1'b0, 1'b0);
    res(3'd1, 1'b0);
    tick();
    chk("mis_after_written", 32'(exp_q.size()), 32'd0);

    // Full queue and wrap-around
    do_reset();
    for (int i = 0; i < 8; i++) enq(10'h040 + 10'(i), 1'b1, 3'(i));
    chk("full_not_ready", 32'(enq_ready), 32'd0);
    enq_valid = 1'b1; enq_idx = 10'h077; enq_pred = 1'b1;
    tick();
    enq_valid = 1'b0;
    chk("full_still_not_ready", 32'(enq_ready), 32'd0);
    push_exp(10'h040, 1'b1, 1'b0);
    res(3'd0, 1'b1);
    chk("full_ready_low_during_retire", 32'(enq_ready), 32'd0);
    tick();
    chk("full_ready_after_retire", 32'(enq_ready), 32'd1);
    enq(10'h050, 1'b0, 3'd0);
    for (int i = 1; i < 8; i++) begin
      push_exp(10'h040 + 10'(i), 1'b1, 1'b0);
      res(3'(i), 1'b1);
    end
    push_exp(10'h050, 1'b0, 1'b0);
    res(3'd0, 1'b0);
    tick();
    tick();
    chk("full_drained", 32'(exp_q.size()), 32'd0);
    chk("full_empty",   32'(empty),        32'd1);

    // Asynchronous reset while updates are in flight
    do_reset();
    enq(10'h101, 1'b1, 3'd0);
    enq(10'h102, 1'b0, 3'd1);
    enq(10'h103, 1'b1, 3'd2);
    res(3'd1, 1'b0);
    res(3'd2, 1'b1);
    push_exp(10'h101, 1'b1, 1'b0);
    res(3'd0, 1'b1);
    tick();
    chk("arst_pre_write", 32'(pht_write), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_pht_write",    32'(pht_write),    32'd0);
    chk("arst_pht_writeidx", 32'(pht_writeidx), 32'd0);
    chk("arst_pht_taken",    32'(pht_taken),    32'd0);
    chk("arst_mispredict",   32'(mispredict),   32'd0);
    chk("arst_empty",        32'(empty),        32'd1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    tick();
    chk("arst_no_write_after", 32'(exp_q.size()), 32'd0);
    chk("arst_still_empty",    32'(empty),        32'd1);

    // Five retires, two of them mispredicts
    do_reset();
`ifdef BRQ_STATS_EN
    chk("stat_retired_reset", stat_retired, 32'd0);
    chk("stat_mispred_reset", stat_mispred, 32'd0);
`endif
    for (int k = 0; k < 5; k++) begin
      s  = enq_slot;
      tk = (k == 1 || k == 3) ? 1'b0 : 1'b1;
      enq(10'h060 + 10'(k), 1'b1, s);
      push_exp(10'h060 + 10'(k), tk, ~tk);
      res(s, tk);
      tick();
    end
    tick();
    chk("stats_drained", 32'(exp_q.size()), 32'd0);
`ifdef BRQ_STATS_EN
    chk("stat_retired", stat_retired, 32'd5);
    chk("stat_mispred", stat_mispred, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
